fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the team's FIFO between N_REQ producer streams.
- Runs in the FIFO write-clock domain and drives buf_in/wr_en directly from the winning requester.
- Round-robin arbitration with bounded bursts; packet boundaries are respected via req_last.
- Back-pressure comes from the FIFO buf_full flag; a running beat counter is provided for debug.

---
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between N_REQ producer streams, the arbiter and the FIFO write side.
// master: the arbiter; slave: the producers and FIFO that surround it.
interface fifo_wr_arbiter_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_REQ  = 4
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    buf_full;
   logic [DATA_W-1:0]       buf_in;
   logic                    wr_en;

   modport master (
      input  req_valid, req_last, req_data, buf_full,
      output req_ready, buf_in, wr_en
   );

   modport slave (
      output req_valid, req_last, req_data, buf_full,
      input  req_ready, buf_in, wr_en
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ streams,
// with bounded bursts, packet-aware release and a wrapping beat counter.
module fifo_wr_arbiter #(
   parameter  int unsigned DATA_W    = 8,
   parameter  int unsigned N_REQ     = 4,
   parameter  int unsigned MAX_BURST = 4,
   parameter  int unsigned CNT_W     = 16,
   localparam int unsigned ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_wr_arbiter_if.master    bus,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic [CNT_W-1:0]     total_beats
);

   localparam int unsigned BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [BC_W-1:0] burst_cnt;

   logic            pick_vld;
   logic [ID_W-1:0] pick_id;
   logic            xfer;
   logic            rel;

   // First valid requester scanning upward from rr_ptr, wrapping at N_REQ.
   always_comb begin
      int unsigned     idx;
      logic [ID_W-1:0] cand;
      pick_vld = 1'b0;
      pick_id  = '0;
      idx      = 0;
      cand     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx  = (32'(rr_ptr) + k) % N_REQ;
         cand = ID_W'(idx);
         if (!pick_vld && bus.req_valid[cand]) begin
            pick_vld = 1'b1;
            pick_id  = cand;
         end
      end
   end

   // Combinational write path from the granted requester straight to the FIFO.
   always_comb begin
      bus.req_ready = '0;
      bus.buf_in    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            bus.buf_in = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
      if (state == GRANT) begin
         bus.req_ready[grant_id] = !bus.buf_full;
      end
      xfer       = (state == GRANT) && bus.req_valid[grant_id] && !bus.buf_full;
      bus.wr_en  = xfer;
      rel        = xfer && (bus.req_last[grant_id] || (burst_cnt == BC_W'(MAX_BURST - 1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         burst_cnt   <= '0;
         total_beats <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant_id  <= pick_id;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) begin
                  total_beats <= total_beats + CNT_W'(1);
                  if (rel) begin
                     // The requester just served drops to lowest priority.
                     rr_ptr    <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                     burst_cnt <= '0;
                     state     <= IDLE;
                  end else begin
                     burst_cnt <= burst_cnt + BC_W'(1);
                  end
               end
            end
         endcase
      end
   end

   assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized
// producers checked against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned NR = 4;
   localparam int unsigned MB = 4;
   localparam int unsigned CW = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    grant_id;
   logic          busy;
   logic [CW-1:0] total_beats;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state.
   bit m_busy;
   int m_gid, m_rr, m_bc, m_total;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.DATA_W(DW), .N_REQ(NR)) bus ();

   fifo_wr_arbiter #(
      .DATA_W(DW), .N_REQ(NR), .MAX_BURST(MB), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .grant_id(grant_id), .busy(busy), .total_beats(total_beats)
   );

   function automatic void model_reset();
      m_busy = 1'b0; m_gid = 0; m_rr = 0; m_bc = 0; m_total = 0;
   endfunction

   function automatic void model_clock();
      if (!m_busy) begin
         for (int k = 0; k < NR; k++) begin
            int idx = (m_rr + k) % NR;
            if (bus.req_valid[idx]) begin
               m_gid = idx; m_bc = 0; m_busy = 1'b1;
               break;
            end
         end
      end else if (!bus.buf_full && bus.req_valid[m_gid]) begin
         m_total = (m_total + 1) % (1 << CW);
         m_bc++;
         if (bus.req_last[m_gid] || m_bc == MB) begin
            m_busy = 1'b0; m_rr = (m_gid + 1) % NR; m_bc = 0;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_clock();
      #1;
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] d);
      bus.req_data[i*DW +: DW] = d;
   endtask

   task automatic idle_inputs();
      bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.buf_full = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      #2 rst_n = 1'b0;
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      repeat (2) tick();
      @(negedge clk);
      n_checks++;
      if ({busy, bus.wr_en, bus.req_ready, grant_id, total_beats} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got=%b exp=0", {busy, bus.wr_en, bus.req_ready, grant_id, total_beats});
      end
      rst_n = 1'b1;
      model_reset();
      repeat (2) tick();
      @(negedge clk);
      n_checks++;
      if ({busy, bus.wr_en, bus.req_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_idle got=%b exp=0", {busy, bus.wr_en, bus.req_ready});
      end
      tick();
   endtask

   task automatic test_single();
      logic [DW-1:0] d3 [3];
      d3 = '{8'h11, 8'h22, 8'h33};
      bus.req_valid = 4'b0100;
      set_data(2, d3[0]);
      @(negedge clk);
      n_checks++;
      if ({busy, bus.wr_en} !== 2'b00) begin
         n_fail++; $display("FAIL single_latency got=%b exp=00", {busy, bus.wr_en});
      end
      tick();
      for (int b = 0; b < 3; b++) begin
         set_data(2, d3[b]);
         bus.req_last[2] = (b == 2);
         @(negedge clk);
         n_checks++;
         if ({busy, bus.wr_en, bus.req_ready, grant_id} !== {1'b1, 1'b1, 4'b0100, 2'd2}) begin
            n_fail++;
            $display("FAIL single_ctrl beat=%0d got=%b exp=%b", b,
                     {busy, bus.wr_en, bus.req_ready, grant_id}, {1'b1, 1'b1, 4'b0100, 2'd2});
         end
         n_checks++;
         if (bus.buf_in !== d3[b]) begin
            n_fail++; $display("FAIL single_data beat=%0d got=%h exp=%h", b, bus.buf_in, d3[b]);
         end
         tick();
      end
      bus.req_valid = '0; bus.req_last = '0;
      @(negedge clk);
      n_checks++;
      if ({busy, bus.wr_en, total_beats} !== {2'b00, 4'd3}) begin
         n_fail++; $display("FAIL single_end got=%b exp=%b", {busy, bus.wr_en, total_beats}, {2'b00, 4'd3});
      end
      // rr_ptr now 3: req 3 must beat req 1.
      bus.req_valid = 4'b1010; bus.req_last = 4'b1010;
      set_data(1, 8'h01); set_data(3, 8'h03);
      tick();
      @(negedge clk);
      n_checks++;
      if ({grant_id, bus.buf_in} !== {2'd3, 8'h03}) begin
         n_fail++; $display("FAIL single_rrptr got=%0d/%h exp=3/03", grant_id, bus.buf_in);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.req_valid = 4'hF;
      for (int i = 0; i < NR; i++) set_data(i, 8'hA0 + 8'(i));
      for (int c = 0; c < 25; c++) begin
         logic          ew;
         logic [1:0]    eg;
         logic [DW-1:0] ed;
         ew = (c % 5) != 0;
         eg = 2'((c / 5) % NR);
         ed = 8'hA0 + 8'(eg);
         @(negedge clk);
         n_checks++;
         if ({busy, bus.wr_en} !== {ew, ew}) begin
            n_fail++; $display("FAIL rr_bubble cyc=%0d got=%b exp=%b", c, {busy, bus.wr_en}, {ew, ew});
         end
         if (ew) begin
            n_checks++;
            if ({grant_id, bus.buf_in} !== {eg, ed}) begin
               n_fail++; $display("FAIL rr_order cyc=%0d got=%0d/%h exp=%0d/%h", c, grant_id, bus.buf_in, eg, ed);
            end
         end
         tick();
      end
      @(negedge clk);
      n_checks++;
      if (total_beats !== CW'(20 % (1 << CW))) begin
         n_fail++; $display("FAIL rr_total got=%0d exp=%0d", total_beats, 20 % (1 << CW));
      end
   endtask

   task automatic test_stall();
      do_reset();
      bus.req_valid = 4'b0010;
      set_data(1, 8'h5A);
      tick();
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.wr_en, bus.req_ready} !== 5'b1_0010) begin
            n_fail++; $display("FAIL stall_pre beat=%0d got=%b exp=10010", b, {bus.wr_en, bus.req_ready});
         end
         tick();
      end
      bus.buf_full = 1'b1;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, bus.wr_en, bus.req_ready, grant_id} !== {1'b1, 1'b0, 4'b0000, 2'd1}) begin
            n_fail++; $display("FAIL stall_hold cyc=%0d got=%b exp=10000001", s,
                               {busy, bus.wr_en, bus.req_ready, grant_id});
         end
         tick();
      end
      bus.buf_full = 1'b0;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.wr_en, bus.req_ready} !== 5'b1_0010) begin
            n_fail++; $display("FAIL stall_post beat=%0d got=%b exp=10010", b, {bus.wr_en, bus.req_ready});
         end
         tick();
      end
      @(negedge clk);
      n_checks++;
      if ({busy, bus.wr_en, total_beats} !== {2'b00, 4'd4}) begin
         n_fail++; $display("FAIL stall_rotate got=%b exp=%b", {busy, bus.wr_en, total_beats}, {2'b00, 4'd4});
      end
   endtask

   task automatic test_rr_priority();
      do_reset();
      bus.req_valid = 4'b0001; bus.req_last = 4'b0001;
      set_data(0, 8'h10); set_data(3, 8'h30);
      tick();
      @(negedge clk);
      n_checks++;
      if ({grant_id, bus.wr_en} !== {2'd0, 1'b1}) begin
         n_fail++; $display("FAIL prio_first got=%b exp=001", {grant_id, bus.wr_en});
      end
      tick();
      bus.req_valid = 4'b1001; bus.req_last = 4'b1001;
      tick();
      @(negedge clk);
      n_checks++;
      if ({grant_id, bus.wr_en, bus.req_ready, bus.buf_in} !== {2'd3, 1'b1, 4'b1000, 8'h30}) begin
         n_fail++; $display("FAIL prio_req3 got=%0d/%b/%b/%h exp=3/1/1000/30",
                            grant_id, bus.wr_en, bus.req_ready, bus.buf_in);
      end
      tick();
      bus.req_valid = 4'b0001;
      tick();
      @(negedge clk);
      n_checks++;
      if ({grant_id, bus.wr_en, bus.buf_in} !== {2'd0, 1'b1, 8'h10}) begin
         n_fail++; $display("FAIL prio_req0 got=%0d/%b/%h exp=0/1/10", grant_id, bus.wr_en, bus.buf_in);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.req_valid = 4'b0100;
      set_data(2, 8'h77);
      repeat (2) tick();
      #2;
      n_checks++;
      if ({busy, bus.wr_en} !== 2'b11) begin
         n_fail++; $display("FAIL areset_pre got=%b exp=11", {busy, bus.wr_en});
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({busy, bus.wr_en, bus.req_ready, grant_id, total_beats} !== '0) begin
         n_fail++; $display("FAIL areset_drop got=%b exp=0",
                            {busy, bus.wr_en, bus.req_ready, grant_id, total_beats});
      end
      bus.req_valid = 4'hF;
      #3 rst_n = 1'b1;
      tick();
      @(negedge clk);
      n_checks++;
      if ({grant_id, bus.wr_en} !== {2'd0, 1'b1}) begin
         n_fail++; $display("FAIL areset_regrant got=%0d/%b exp=0/1", grant_id, bus.wr_en);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_wrap();
      int beats = 0;
      int cyc   = 0;
      do_reset();
      bus.req_valid = 4'b0001;
      set_data(0, 8'h99);
      while (beats < 17 && cyc < 100) begin
         @(negedge clk);
         if (bus.wr_en === 1'b1) beats++;
         tick();
         cyc++;
         if (beats == 17) bus.req_valid = '0;
      end
      n_checks++;
      if (beats != 17) begin
         n_fail++; $display("FAIL wrap_timeout got=%0d beats exp=17", beats);
      end
      @(negedge clk);
      n_checks++;
      if (total_beats !== CW'(17 % (1 << CW))) begin
         n_fail++; $display("FAIL wrap_total got=%0d exp=%0d", total_beats, 17 % (1 << CW));
      end
      idle_inputs();
   endtask

   task automatic test_random();
      int pkt_left [NR];
      do_reset();
      for (int i = 0; i < NR; i++) pkt_left[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [NR-1:0] er;
         logic [NR-1:0] acc;
         logic          ew;
         for (int i = 0; i < NR; i++) begin
            if (pkt_left[i] == 0 && $urandom_range(0, 2) == 0) begin
               pkt_left[i] = $urandom_range(1, 6);
               set_data(i, DW'($urandom));
            end
            bus.req_valid[i] = (pkt_left[i] != 0);
            bus.req_last[i]  = (pkt_left[i] == 1);
         end
         bus.buf_full = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         er = '0;
         if (m_busy && !bus.buf_full) er[m_gid] = 1'b1;
         acc = er & bus.req_valid;
         ew  = |acc;
         n_checks++;
         if ({busy, bus.wr_en, bus.req_ready} !== {m_busy, ew, er}) begin
            n_fail++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", cyc,
                               {busy, bus.wr_en, bus.req_ready}, {m_busy, ew, er});
         end
         n_checks++;
         if ({grant_id, total_beats} !== {2'(m_gid), CW'(m_total)}) begin
            n_fail++; $display("FAIL rand_state cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                               grant_id, total_beats, m_gid, m_total);
         end
         if (ew) begin
            n_checks++;
            if (bus.buf_in !== bus.req_data[m_gid*DW +: DW]) begin
               n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc,
                                  bus.buf_in, bus.req_data[m_gid*DW +: DW]);
            end
         end
         tick();
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
               pkt_left[i]--;
               set_data(i, DW'($urandom));
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_rr_priority();
      test_async_reset();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
